clkgate_seq: RTL and testbench
==============================

CLKGATE_SEQ -- requirements
Module: clkgate_seq

Interface
REQ-001 The block SHALL have parameter NBR, default 4, giving the number of gated clock branches (2..16).
REQ-002 The block SHALL have parameter GAP, default 2, giving the number of hold cycles after any EN change (1..15).
REQ-003 The block SHALL have parameter SETTLE, default 3, giving the number of cycles from EN rise to ACK rise (1..15).
REQ-004 CLK  input  1  block clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 REQ  input  NBR  per-branch clock request from consumers; level-sensitive.
REQ-007 TE  input  1  test enable; forces all EN outputs high.
REQ-008 EN  output  NBR  per-branch enable to clock-gate cells feeding each clkbuf tree.
REQ-009 ACK  output  NBR  per-branch "clock stable" acknowledge.
REQ-010 BUSY  output  1  high while the sequencer is in HOLD.
REQ-011 VDD, VSS  inout  1  supply pins; carry no function.

Function
REQ-012 The block SHALL keep an internal enable register ENR[NBR-1:0]; EN SHALL equal ENR OR'd with {NBR{TE}}, combinationally.
REQ-013 Branch i SHALL be pending when REQ[i] differs from ENR[i].
REQ-014 The FSM SHALL have two states: IDLE and HOLD.
REQ-015 In IDLE with at least one pending branch, the block SHALL select the first pending index at or after pointer PTR, wrapping past NBR-1 to 0.
REQ-016 On that edge it SHALL toggle ENR[sel], set PTR to (sel+1) mod NBR, load hold counter HC with GAP, and enter HOLD.
REQ-017 In IDLE with no pending branch, the block SHALL leave state, PTR and ENR unchanged.
REQ-018 In HOLD, HC SHALL decrement by 1 each cycle; the block SHALL return to IDLE on the edge where HC goes 1->0.
REQ-019 With requests continuously pending, successive ENR toggles SHALL occur exactly GAP+1 edges apart, and never closer.
REQ-020 Exactly one ENR bit SHALL change per toggle edge.
REQ-021 REQ changes during HOLD SHALL be evaluated only at the next IDLE cycle; no request is lost or queued beyond its level.
REQ-022 A REQ pulse that returns to ENR's value before being selected SHALL cause no EN change.
REQ-023 Each branch SHALL have a settle counter that loads SETTLE on the edge where ENR[i] rises.
REQ-024 That counter SHALL decrement while ENR[i]=1; ACK[i] SHALL rise on the edge where it reaches 0, i.e. SETTLE edges after ENR[i] rose.
REQ-025 ACK[i] SHALL fall on the same edge ENR[i] falls, and the settle counter SHALL clear on that edge.
REQ-026 ACK SHALL depend on ENR only; TE SHALL NOT affect ACK, ENR, PTR or the FSM.
REQ-027 BUSY SHALL be 1 exactly when the state is HOLD; BUSY is registered.

Reset
REQ-028 While RST=1, the block SHALL hold ENR=0, EN=TE-replicated, ACK=0, BUSY=0, PTR=0, HC=0, all settle counters=0, and state IDLE.
REQ-029 Assertion of RST mid-HOLD or mid-settle SHALL abort the operation immediately, without waiting for a clock edge.
REQ-030 After RST falls, the first rising CLK edge SHALL evaluate pending branches normally from IDLE.

Verification (NBR=4, GAP=2, SETTLE=3)
REQ-031 Single request: REQ=0001 sampled at edge 1 -> EN=0001 after edge 1; BUSY=1 after edges 1 and 2, 0 after edge 3; ACK=0001 after edge 4.
REQ-032 All request, PTR=0: REQ=1111 at edge 1 -> EN bits 0,1,2,3 rise after edges 1,4,7,10; ACK bits rise after edges 4,7,10,13.
REQ-033 Round robin: after branch 1 is served (PTR=2), with pending branches {0,3} -> branch 3 toggles first, then branch 0 three edges later.
REQ-034 Release: with EN=0100 and ACK=0100, REQ[2] drops -> ENR[2] and ACK[2] both fall on the next IDLE edge; a REQ pulse 1 cycle wide during HOLD produces no EN change.
REQ-035 Reset mid-HOLD: RST pulses while BUSY=1 and EN=0011 -> EN, ACK, BUSY read 0 before the next edge; after release, REQ=0011 re-sequences starting at branch 0.
REQ-036 Test mode: TE=1 with REQ=0 -> EN=1111 combinationally, ACK=0000, BUSY=0; TE=0 -> EN=0000.

Source files
------------

// File: rtl/clkgate_seq.sv
// Clock-gate enable sequencer: toggles one branch enable at a time, round-robin,
// spaced GAP+1 edges apart, and raises a per-branch ACK SETTLE edges after enable rise.
module clkgate_seq #(
    parameter int NBR    = 4,
    parameter int GAP    = 2,
    parameter int SETTLE = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NBR-1:0] req_i,
    input  logic           te_i,
    output logic [NBR-1:0] en_o,
    output logic [NBR-1:0] ack_o,
    output logic           busy_o,
    inout  wire            vdd_io,
    inout  wire            vss_io
);

    localparam int PW = (NBR > 1) ? $clog2(NBR) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NBR-1:0]         enr_q, enr_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [3:0]             hc_q, hc_d;
    logic [NBR-1:0][3:0]    cnt_q, cnt_d;
    logic [NBR-1:0]         ack_q, ack_d;

    logic [NBR-1:0]         pend;
    logic                   sel_vld;
    logic [PW-1:0]          sel;

    // Supply pins exist only for the netlist; nothing inside depends on them.
    wire unused_supply = vdd_io ^ vss_io;

    // First pending branch at or after the pointer, wrapping.
    always_comb begin
        pend    = req_i ^ enr_q;
        sel_vld = 1'b0;
        sel     = '0;
        for (int k = 0; k < NBR; k++) begin
            if (!sel_vld && pend[(int'(ptr_q) + k) % NBR]) begin
                sel_vld = 1'b1;
                sel     = PW'((int'(ptr_q) + k) % NBR);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            enr_q   <= '0;
            ptr_q   <= '0;
            hc_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            enr_q   <= enr_d;
            ptr_q   <= ptr_d;
            hc_q    <= hc_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        enr_d   = enr_q;
        ptr_d   = ptr_q;
        hc_d    = hc_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    enr_d[sel] = ~enr_q[sel];
                    ptr_d      = (sel == PW'(NBR - 1)) ? '0 : sel + PW'(1);
                    hc_d       = 4'(GAP);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                hc_d = hc_q - 4'd1;
                if (hc_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Settle counters follow the next-state enable so ACK falls on the same edge as ENR.
    always_comb begin
        cnt_d = cnt_q;
        ack_d = ack_q;
        for (int i = 0; i < NBR; i++) begin
            if (!enr_d[i]) begin
                cnt_d[i] = 4'd0;
                ack_d[i] = 1'b0;
            end else if (!enr_q[i]) begin
                cnt_d[i] = 4'(SETTLE);
                ack_d[i] = 1'b0;
            end else if (cnt_q[i] != 4'd0) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
                if (cnt_q[i] == 4'd1) begin
                    ack_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        en_o   = enr_q | {NBR{te_i}};
        ack_o  = ack_q;
        busy_o = (state_q == HOLD);
    end

endmodule

// File: tb/tb_clkgate_seq.sv
// Scoreboard bench for clkgate_seq at NBR=4, GAP=2, SETTLE=3.
module tb_clkgate_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic       te_i  = 1'b0;
    logic [3:0] en_o;
    logic [3:0] ack_o;
    logic       busy_o;
    wire        vdd_io;
    wire        vss_io;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] en;
        logic [3:0] ack;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    clkgate_seq #(.NBR(4), .GAP(2), .SETTLE(3)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .te_i   (te_i),
        .en_o   (en_o),
        .ack_o  (ack_o),
        .busy_o (busy_o),
        .vdd_io (vdd_io),
        .vss_io (vss_io)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] en, input logic [3:0] ack, input logic busy);
        exp_t e;
        e.tag = tag; e.en = en; e.ack = ack; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".en"},   32'(en_o),   32'(e.en));
            chk({e.tag, ".ack"},  32'(ack_o),  32'(e.ack));
            chk({e.tag, ".busy"}, 32'(busy_o), 32'(e.busy));
        end
    endtask

    // Expect the given outputs just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] en, input logic [3:0] ack, input logic busy);
        push(tag, en, ack, busy);
        @(posedge clk_i);
        #1;
        observe();
    endtask

    // Called 1 time unit after an edge (or at t=0); finishes well before the next edge.
    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        #2;
        push(tag, {4{te_i}}, 4'b0000, 1'b0);
        observe();
        rst_i = 1'b0;
        #2;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [3:0] e_en, e_ack;
        logic       e_busy;

        // Single request
        do_reset("rst0");
        req_i = 4'b0001;
        step("s1.e1", 4'b0001, 4'b0000, 1'b1);
        step("s1.e2", 4'b0001, 4'b0000, 1'b1);
        step("s1.e3", 4'b0001, 4'b0000, 1'b0);
        step("s1.e4", 4'b0001, 4'b0001, 1'b0);
        req_i = 4'b0000;
        step("s1.off", 4'b0000, 4'b0000, 1'b1);

        // All request from PTR=0: enables at 1,4,7,10, acks at 4,7,10,13
        do_reset("rst1");
        req_i = 4'b1111;
        for (int k = 1; k <= 13; k++) begin
            e_en = '0; e_ack = '0;
            for (int b = 0; b < 4; b++) begin
                if (k >= 1 + 3 * b) e_en[b] = 1'b1;
                if (k >= 4 + 3 * b) e_ack[b] = 1'b1;
            end
            e_busy = (k <= 11) && (((k - 1) % 3) != 2);
            step($sformatf("all.e%0d", k), e_en, e_ack, e_busy);
        end

        // Round robin: serve branch 1, then {0,3} pending -> 3 before 0
        do_reset("rst2");
        req_i = 4'b0010;
        step("rr.e1", 4'b0010, 4'b0000, 1'b1);
        req_i = 4'b1011;
        step("rr.e2", 4'b0010, 4'b0000, 1'b1);
        step("rr.e3", 4'b0010, 4'b0000, 1'b0);
        step("rr.e4", 4'b1010, 4'b0010, 1'b1);
        step("rr.e5", 4'b1010, 4'b0010, 1'b1);
        step("rr.e6", 4'b1010, 4'b0010, 1'b0);
        step("rr.e7", 4'b1011, 4'b1010, 1'b1);
        step("rr.e8", 4'b1011, 4'b1010, 1'b1);
        step("rr.e9", 4'b1011, 4'b1010, 1'b0);
        step("rr.e10", 4'b1011, 4'b1011, 1'b0);

        // Release and short pulse during HOLD
        req_i = 4'b0000;
        do_reset("rst3");
        req_i = 4'b0100;
        step("rel.e1", 4'b0100, 4'b0000, 1'b1);
        step("rel.e2", 4'b0100, 4'b0000, 1'b1);
        step("rel.e3", 4'b0100, 4'b0000, 1'b0);
        step("rel.e4", 4'b0100, 4'b0100, 1'b0);
        req_i = 4'b0000;
        step("rel.drop", 4'b0000, 4'b0000, 1'b1);
        step("rel.e6", 4'b0000, 4'b0000, 1'b1);
        step("rel.e7", 4'b0000, 4'b0000, 1'b0);
        req_i = 4'b0001;
        step("pul.e1", 4'b0001, 4'b0000, 1'b1);
        req_i = 4'b0011;
        step("pul.e2", 4'b0001, 4'b0000, 1'b1);
        req_i = 4'b0001;
        step("pul.e3", 4'b0001, 4'b0000, 1'b0);
        step("pul.e4", 4'b0001, 4'b0001, 1'b0);
        step("pul.e5", 4'b0001, 4'b0001, 1'b0);

        // Reset mid-HOLD with EN=0011, then re-sequence from branch 0
        req_i = 4'b0000;
        do_reset("rst4");
        req_i = 4'b0011;
        step("mh.e1", 4'b0001, 4'b0000, 1'b1);
        step("mh.e2", 4'b0001, 4'b0000, 1'b1);
        step("mh.e3", 4'b0001, 4'b0000, 1'b0);
        step("mh.e4", 4'b0011, 4'b0001, 1'b1);
        do_reset("mh.async");
        step("mh.r1", 4'b0001, 4'b0000, 1'b1);
        step("mh.r2", 4'b0001, 4'b0000, 1'b1);
        step("mh.r3", 4'b0001, 4'b0000, 1'b0);
        step("mh.r4", 4'b0011, 4'b0001, 1'b1);

        // Test mode
        req_i = 4'b0000;
        do_reset("rst5");
        te_i = 1'b1;
        #1;
        push("te.on", 4'b1111, 4'b0000, 1'b0);
        observe();
        step("te.e1", 4'b1111, 4'b0000, 1'b0);
        step("te.e2", 4'b1111, 4'b0000, 1'b0);
        te_i = 1'b0;
        #1;
        push("te.off", 4'b0000, 4'b0000, 1'b0);
        observe();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
